// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each functional unit result lands in a one-entry
// holding buffer. A round-robin arbiter picks one buffered result per cycle
// and drives it onto the registered CDB that feeds the ROB, the regfile and
// the RS wakeup logic.
module cdb_arbiter #(
   parameter int NUM_FU        = 4,
   parameter int PHYS_REG_BITS = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [NUM_FU-1:0]               fu_valid,
   output logic [NUM_FU-1:0]               fu_ready,
   input  logic [NUM_FU*PHYS_REG_BITS-1:0] fu_pd,
   input  logic [NUM_FU*5-1:0]             fu_rd,
   input  logic [NUM_FU*PHYS_REG_BITS-1:0] fu_rob_num,
   input  logic [NUM_FU*32-1:0]            fu_data,
   output logic                            cdb_valid,
   output logic [PHYS_REG_BITS-1:0]        cdb_pd,
   output logic [4:0]                      cdb_rd,
   output logic [PHYS_REG_BITS-1:0]        cdb_rob_num,
   output logic [31:0]                     cdb_data,
   output logic                            cdb_regf_we,
   output logic [2:0]                      cdb_fu_id
);

   localparam logic [2:0] LAST_FU = 3'(NUM_FU - 1);

   logic [NUM_FU-1:0]        buf_valid;
   logic [PHYS_REG_BITS-1:0] buf_pd      [NUM_FU];
   logic [4:0]               buf_rd      [NUM_FU];
   logic [PHYS_REG_BITS-1:0] buf_rob_num [NUM_FU];
   logic [31:0]              buf_data    [NUM_FU];

   logic [2:0]               rr_ptr;
   logic [NUM_FU-1:0]        grant;
   logic                     win_valid;
   logic [2:0]               win_id;
   logic [PHYS_REG_BITS-1:0] win_pd;
   logic [4:0]               win_rd;
   logic [PHYS_REG_BITS-1:0] win_rob_num;
   logic [31:0]              win_data;

   // A buffer frees up when empty or when it is being broadcast this cycle;
   // flush blocks every accept so nothing new slips in during a squash.
   assign fu_ready = flush ? '0 : (~buf_valid | grant);

   // Round-robin scan from rr_ptr, then a one-hot mux of the winner's payload.
   always_comb begin
      int idx;
      grant       = '0;
      win_valid   = 1'b0;
      win_id      = '0;
      win_pd      = '0;
      win_rd      = '0;
      win_rob_num = '0;
      win_data    = '0;
      idx         = 0;
      if (!flush) begin
         for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            for (int i = 0; i < NUM_FU; i++) begin
               if (i == idx && buf_valid[i] && !win_valid) begin
                  grant[i]  = 1'b1;
                  win_valid = 1'b1;
               end
            end
         end
      end
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) begin
            win_id      = 3'(i);
            win_pd      = buf_pd[i];
            win_rd      = buf_rd[i];
            win_rob_num = buf_rob_num[i];
            win_data    = buf_data[i];
         end
      end
   end

   // Buffer occupancy: accept wins over the grant clear so an uncontested FU
   // can stream one result per cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid <= '0;
      end else if (flush) begin
         buf_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) buf_valid[i] <= 1'b1;
            else if (grant[i])              buf_valid[i] <= 1'b0;
         end
      end
   end

   // Buffer payload: only meaningful while buf_valid is set, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (fu_valid[i] && fu_ready[i]) begin
            buf_pd[i]      <= fu_pd[i*PHYS_REG_BITS +: PHYS_REG_BITS];
            buf_rd[i]      <= fu_rd[i*5 +: 5];
            buf_rob_num[i] <= fu_rob_num[i*PHYS_REG_BITS +: PHYS_REG_BITS];
            buf_data[i]    <= fu_data[i*32 +: 32];
         end
      end
   end

   // Registered broadcast and round-robin pointer advance past the winner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_valid   <= 1'b0;
         cdb_regf_we <= 1'b0;
         cdb_pd      <= '0;
         cdb_rd      <= '0;
         cdb_rob_num <= '0;
         cdb_data    <= '0;
         cdb_fu_id   <= '0;
         rr_ptr      <= '0;
      end else if (flush) begin
         cdb_valid   <= 1'b0;
         cdb_regf_we <= 1'b0;
         rr_ptr      <= '0;
      end else if (win_valid) begin
         cdb_valid   <= 1'b1;
         cdb_regf_we <= (win_rd != 5'd0);
         cdb_pd      <= win_pd;
         cdb_rd      <= win_rd;
         cdb_rob_num <= win_rob_num;
         cdb_data    <= win_data;
         cdb_fu_id   <= win_id;
         rr_ptr      <= (win_id == LAST_FU) ? 3'd0 : win_id + 3'd1;
      end else begin
         cdb_valid   <= 1'b0;
         cdb_regf_we <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single request, round-robin rotation,
// per-FU streaming, flush, rd=0 broadcast and async reset mid-operation.
module tb_cdb_arbiter;

   localparam int NUM_FU = 4;
   localparam int PRB    = 6;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    flush = 1'b0;
   logic [NUM_FU-1:0]       fu_valid = '0;
   logic [NUM_FU-1:0]       fu_ready;
   logic [NUM_FU*PRB-1:0]   fu_pd = '0;
   logic [NUM_FU*5-1:0]     fu_rd = '0;
   logic [NUM_FU*PRB-1:0]   fu_rob_num = '0;
   logic [NUM_FU*32-1:0]    fu_data = '0;
   logic                    cdb_valid;
   logic [PRB-1:0]          cdb_pd;
   logic [4:0]              cdb_rd;
   logic [PRB-1:0]          cdb_rob_num;
   logic [31:0]             cdb_data;
   logic                    cdb_regf_we;
   logic [2:0]              cdb_fu_id;

   int total = 0;
   int bad   = 0;

   cdb_arbiter #(.NUM_FU(NUM_FU), .PHYS_REG_BITS(PRB)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fu_valid(fu_valid), .fu_ready(fu_ready),
      .fu_pd(fu_pd), .fu_rd(fu_rd), .fu_rob_num(fu_rob_num), .fu_data(fu_data),
      .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rd(cdb_rd),
      .cdb_rob_num(cdb_rob_num), .cdb_data(cdb_data),
      .cdb_regf_we(cdb_regf_we), .cdb_fu_id(cdb_fu_id)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fu(input int i, input logic [PRB-1:0] pd, input logic [4:0] rd,
                         input logic [PRB-1:0] rob, input logic [31:0] data);
      fu_pd[i*PRB +: PRB]      = pd;
      fu_rd[i*5 +: 5]          = rd;
      fu_rob_num[i*PRB +: PRB] = rob;
      fu_data[i*32 +: 32]      = data;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_we", 64'(cdb_regf_we), 64'd0);
      chk("rst_data", 64'(cdb_data), 64'd0);
      chk("rst_pd", 64'(cdb_pd), 64'd0);
      chk("rst_fuid", 64'(cdb_fu_id), 64'd0);
      #2 rst = 1'b1;
      #1 chk("rst_ready", 64'(fu_ready), 64'hF);

      // Single request from FU1
      set_fu(1, 6'd5, 5'd3, 6'd7, 32'hDEADBEEF);
      fu_valid = 4'b0010;
      tick();
      chk("single_lat", 64'(cdb_valid), 64'd0);
      fu_valid = '0;
      tick();
      chk("single_valid", 64'(cdb_valid), 64'd1);
      chk("single_pd", 64'(cdb_pd), 64'd5);
      chk("single_rd", 64'(cdb_rd), 64'd3);
      chk("single_rob", 64'(cdb_rob_num), 64'd7);
      chk("single_data", 64'(cdb_data), 64'hDEADBEEF);
      chk("single_fuid", 64'(cdb_fu_id), 64'd1);
      chk("single_we", 64'(cdb_regf_we), 64'd1);
      tick();
      chk("single_drop", 64'(cdb_valid), 64'd0);
      chk("single_we0", 64'(cdb_regf_we), 64'd0);
      chk("single_hold", 64'(cdb_data), 64'hDEADBEEF);

      // Empty flush to bring rr_ptr back to 0
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // All four FUs held valid: strict rotation 0,1,2,3,0,1
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(10 + i), 5'(i + 1), 6'(20 + i), 32'(100 + i));
      fu_valid = 4'b1111;
      tick();
      chk("rr_lat", 64'(cdb_valid), 64'd0);
      chk("rr_ready0", 64'(fu_ready), 64'b0001);
      for (int n = 0; n < 6; n++) begin
         tick();
         chk("rr_valid", 64'(cdb_valid), 64'd1);
         chk("rr_fuid", 64'(cdb_fu_id), 64'(n % 4));
         chk("rr_data", 64'(cdb_data), 64'(100 + n % 4));
         chk("rr_ready", 64'(fu_ready), 64'(1 << ((n + 1) % 4)));
      end

      // Flush with all buffers full
      fu_valid = '0;
      flush = 1'b1;
      #1 chk("flush_ready", 64'(fu_ready), 64'd0);
      tick();
      chk("flush_valid", 64'(cdb_valid), 64'd0);
      flush = 1'b0;
      #1 chk("flush_ready_after", 64'(fu_ready), 64'hF);
      tick();
      chk("flush_nostale", 64'(cdb_valid), 64'd0);

      // FU2 streaming 1,2,3,4 alone
      set_fu(2, 6'd9, 5'd4, 6'd11, 32'd1);
      fu_valid = 4'b0100;
      tick();
      chk("stream_ready0", 64'(fu_ready[2]), 64'd1);
      for (int k = 1; k <= 3; k++) begin
         fu_data[2*32 +: 32] = 32'(k + 1);
         tick();
         chk("stream_valid", 64'(cdb_valid), 64'd1);
         chk("stream_fuid", 64'(cdb_fu_id), 64'd2);
         chk("stream_data", 64'(cdb_data), 64'(k));
         chk("stream_ready", 64'(fu_ready[2]), 64'd1);
      end
      fu_valid = '0;
      tick();
      chk("stream_last", 64'(cdb_data), 64'd4);
      chk("stream_last_v", 64'(cdb_valid), 64'd1);
      tick();
      chk("stream_idle", 64'(cdb_valid), 64'd0);

      // Flush with buffers 0 and 3 full (rr_ptr is 3 here)
      set_fu(0, 6'd1, 5'd1, 6'd1, 32'hAAAA0000);
      set_fu(3, 6'd2, 5'd2, 6'd2, 32'hBBBB0003);
      fu_valid = 4'b1001;
      tick();
      fu_valid = '0;
      flush = 1'b1;
      #1 chk("flush03_ready", 64'(fu_ready), 64'd0);
      tick();
      chk("flush03_valid", 64'(cdb_valid), 64'd0);
      flush = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("flush03_nostale", 64'(cdb_valid), 64'd0);
      end
      // rr_ptr back at 0: FU1 must beat FU3
      set_fu(1, 6'd3, 5'd3, 6'd3, 32'h11110001);
      set_fu(3, 6'd4, 5'd4, 6'd4, 32'h33330003);
      fu_valid = 4'b1010;
      tick();
      fu_valid = '0;
      tick();
      chk("flush_rr_first", 64'(cdb_fu_id), 64'd1);
      chk("flush_rr_data1", 64'(cdb_data), 64'h11110001);
      tick();
      chk("flush_rr_second", 64'(cdb_fu_id), 64'd3);
      chk("flush_rr_data3", 64'(cdb_data), 64'h33330003);
      tick();
      chk("flush_rr_idle", 64'(cdb_valid), 64'd0);

      // rd = 0 from FU0: broadcast but no regfile write
      set_fu(0, 6'd8, 5'd0, 6'd9, 32'h00000055);
      fu_valid = 4'b0001;
      tick();
      fu_valid = '0;
      tick();
      chk("rd0_valid", 64'(cdb_valid), 64'd1);
      chk("rd0_we", 64'(cdb_regf_we), 64'd0);
      chk("rd0_fuid", 64'(cdb_fu_id), 64'd0);
      tick();
      chk("rd0_idle", 64'(cdb_valid), 64'd0);

      // Async reset mid-cycle with FU1..3 buffered and FU0 on the bus
      set_fu(0, 6'd1, 5'd1, 6'd1, 32'h0000F000);
      fu_valid = 4'b0001;
      tick();
      for (int i = 1; i < NUM_FU; i++) set_fu(i, 6'(i), 5'(i), 6'(i), 32'(32'hF000 + i));
      fu_valid = 4'b1110;
      tick();
      fu_valid = '0;
      chk("arst_pre_valid", 64'(cdb_valid), 64'd1);
      chk("arst_pre_ready", 64'(fu_ready), 64'b0011);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", 64'(cdb_valid), 64'd0);
      chk("arst_data", 64'(cdb_data), 64'd0);
      chk("arst_we", 64'(cdb_regf_we), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("arst_ready", 64'(fu_ready), 64'hF);
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("arst_nobcast", 64'(cdb_valid), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
